div: RTL and testbench
======================

// Module: div
// PURPOSE
//  Iterative radix-2 restoring divider; the inverse counterpart of the EXU combinational multiplier.
//  Serves RV64M DIV/DIVU/REM/REMU and the DIVW/DIVUW/REMW/REMUW word variants.
//  Sits in the EXU next to mult; operands arrive from the EXU issue path and results return on a valid/ready pair.
//  Multi-cycle: exactly one division is in flight at a time.
// PARAMETERS
//  W  64  datapath width; only 64 is supported (word ops use W/2).
// PORTS
//  i_clk     in   1  clock; all state updates on the rising edge
//  i_rst_n   in   1  asynchronous reset, active-low
//  i_flush   in   1  pipeline flush; aborts any operation in flight
//  i_valid   in   1  request valid
//  o_ready   out  1  divider can accept a request (high only in IDLE)
//  i_divw    in   1  word op: use i_x/i_y[W/2-1:0]; results are sign-extended to W bits
//  i_sign    in   1  signed operation (DIV/REM/DIVW/REMW)
//  i_x       in   W  dividend
//  i_y       in   W  divisor
//  o_valid   out  1  result valid
//  i_ready   in   1  consumer accepts the result
//  o_quot    out  W  quotient
//  o_rem     out  W  remainder
// BEHAVIOUR
//  Reset values: o_ready=1, o_valid=0, o_quot=0, o_rem=0; FSM in IDLE.
//  FSM states: IDLE, CALC, DONE.
//   IDLE->CALC : i_valid&&o_ready&&!i_flush and no special case. Capture |x|, |y|, sign of quotient (xs^ys) and sign of remainder (xs); load the counter with N.
//   IDLE->DONE : i_valid&&o_ready&&!i_flush and a special case. The result is produced directly, 1-cycle latency.
//   CALC       : one restoring step per cycle: {rem,quo} <<= 1; if rem>=|y| then rem-=|y| and quo[0]=1. Counter decrements.
//   CALC->DONE : the cycle the counter reaches 0. Apply the sign fix (negate quo if qs; negate rem if rs). Register the outputs.
//   DONE       : o_valid=1 with outputs held stable; DONE->IDLE on i_ready. o_valid drops in the following cycle.
//  Iteration count N: 64 for full-width ops, 32 for word ops.
//  Latency from accept to o_valid: N+1 cycles (65 or 33); 1 cycle for special cases.
//  Operand prep:
//   - Word op: the 32-bit operands are sign-extended when i_sign, zero-extended otherwise.
//   - Absolute value is taken only when i_sign.
//  Special cases (RISC-V spec):
//   - divisor==0: quot = all ones; rem = dividend.
//   - signed overflow (x = most negative value, y = -1): quot = x; rem = 0.
//   - Word variants apply both rules on 32 bits, then sign-extend.
//  Word results: o_quot = {{32{q[31]}}, q[31:0]} and the same for o_rem, signed or not.
//  Flush: forces IDLE in the next cycle from any state and drops o_valid. A flush takes priority over a new accept in the same cycle.
//  Reset mid-operation: immediate return to the reset values; the partial state is discarded.
//  A request while busy is not accepted (o_ready=0). The upstream stage holds i_valid and its operands.
// STRUCTURE
//  Shared package div_pkg:
//   - typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_DONE} div_state_e
//   - localparam DIV_CNT_W = 7
//  Sub-module div_prep (combinational):
//   - inputs: i_divw, i_sign, i_x, i_y
//   - outputs: |x|, |y|, qs, rs, N, and the special-case flag with its precomputed result
//  Top level holds the FSM, counter, shift registers (W-bit rem, W-bit quo), W+1-bit subtractor and sign-fix negators.
// TESTING
//  1. DIVU x=100, y=7: o_valid exactly 65 cycles after accept; quot=14, rem=2; o_ready low throughout.
//  2. DIV x=-7, y=2 -> quot=-3 (0xFFFF_FFFF_FFFF_FFFD), rem=-1. REM x=7, y=-2 -> rem=1.
//  3. DIVU y=0, x=0x1234 -> quot=0xFFFF_FFFF_FFFF_FFFF, rem=0x1234 after 1 cycle. DIV x=0x8000_0000_0000_0000, y=-1 -> quot=x, rem=0.
//  4. DIVUW x=0xFFFF_FFFF, y=1 -> quot=0xFFFF_FFFF_FFFF_FFFF (sign-extended), rem=0, latency 33. DIVW x=0x8000_0000, y=-1 -> quot=0xFFFF_FFFF_8000_0000.
//  5. Backpressure: hold i_ready=0 for 10 cycles in DONE -> o_valid and outputs stable; accept resumes on the cycle after the handshake.
//  6. Flush at CALC cycle 20, and i_rst_n pulsed mid-CALC -> IDLE, o_valid=0; the next request computes 81/9 = 9, rem 0.

Source files
------------

// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared types and constants for the iterative radix-2
//                restoring divider (state encoding, counter width, helpers).
//  Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    // Iteration counter must hold 64 (full-width op count).
    localparam int DIV_CNT_W = 7;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Sign-extend the low word of a 64-bit value to the full width.
    function automatic logic [63:0] sext32(input logic [63:0] v);
        return {{32{v[31]}}, v[31:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_prep.sv
`default_nettype none
// ============================================================================
//  Module      : div_prep
//  Description : Combinational operand preparation for the divider: operand
//                extension for word ops, absolute values, result signs,
//                iteration count and the RISC-V special-case results.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_prep
    import div_pkg::*;
#(
    parameter int W = 64
) (
    input  logic                 i_divw,
    input  logic                 i_sign,
    input  logic [W-1:0]         i_x,
    input  logic [W-1:0]         i_y,
    output logic [W-1:0]         o_abs_x,
    output logic [W-1:0]         o_abs_y,
    output logic                 o_qs,
    output logic                 o_rs,
    output logic [DIV_CNT_W-1:0] o_n,
    output logic                 o_special,
    output logic [W-1:0]         o_spec_quot,
    output logic [W-1:0]         o_spec_rem
);

    localparam int H = W / 2;

    logic [W-1:0] w_x_ext;
    logic [W-1:0] w_y_ext;
    logic [W-1:0] w_min_neg;
    logic         w_x_neg;
    logic         w_y_neg;
    logic         w_y_zero;
    logic         w_ovf;
    logic [W-1:0] w_quot_raw;
    logic [W-1:0] w_rem_raw;

    // Extend operands, take magnitudes and detect the special cases.
    always_comb begin
        w_x_ext = i_x;
        w_y_ext = i_y;
        if (i_divw) begin
            w_x_ext = i_sign ? {{H{i_x[H-1]}}, i_x[H-1:0]} : {{H{1'b0}}, i_x[H-1:0]};
            w_y_ext = i_sign ? {{H{i_y[H-1]}}, i_y[H-1:0]} : {{H{1'b0}}, i_y[H-1:0]};
        end

        w_x_neg = i_sign & w_x_ext[W-1];
        w_y_neg = i_sign & w_y_ext[W-1];

        o_abs_x = w_x_neg ? (~w_x_ext + 1'b1) : w_x_ext;
        o_abs_y = w_y_neg ? (~w_y_ext + 1'b1) : w_y_ext;
        o_qs    = w_x_neg ^ w_y_neg;
        o_rs    = w_x_neg;
        o_n     = i_divw ? DIV_CNT_W'(H) : DIV_CNT_W'(W);

        // Most negative value in extended form: word ops see it sign-extended.
        w_min_neg = i_divw ? {{(H + 1){1'b1}}, {(H - 1){1'b0}}}
                           : {1'b1, {(W - 1){1'b0}}};

        w_y_zero  = (w_y_ext == '0);
        w_ovf     = i_sign & (w_x_ext == w_min_neg) & (w_y_ext == '1);
        o_special = w_y_zero | w_ovf;

        w_quot_raw = w_y_zero ? '1 : w_x_ext;
        w_rem_raw  = w_y_zero ? w_x_ext : '0;

        o_spec_quot = i_divw ? sext32(w_quot_raw) : w_quot_raw;
        o_spec_rem  = i_divw ? sext32(w_rem_raw)  : w_rem_raw;
    end

endmodule
`default_nettype wire

// File: rtl/div.sv
`default_nettype none
// ============================================================================
//  Module      : div
//  Description : Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/
//                REMU and the word variants. One division in flight; results
//                are returned on a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module div
    import div_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_flush,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic         i_divw,
    input  logic         i_sign,
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_y,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_quot,
    output logic [W-1:0] o_rem
);

    localparam int H = W / 2;

    div_state_e           state_q, state_d;
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]         rem_q, rem_d;
    logic [W-1:0]         quo_q, quo_d;
    logic [W-1:0]         abs_y_q, abs_y_d;
    logic                 qs_q, qs_d;
    logic                 rs_q, rs_d;
    logic                 divw_q, divw_d;
    logic [W-1:0]         res_quot_q, res_quot_d;
    logic [W-1:0]         res_rem_q, res_rem_d;

    logic [W-1:0]         w_abs_x;
    logic [W-1:0]         w_abs_y;
    logic                 w_qs;
    logic                 w_rs;
    logic [DIV_CNT_W-1:0] w_n;
    logic                 w_special;
    logic [W-1:0]         w_spec_quot;
    logic [W-1:0]         w_spec_rem;

    logic [W:0]           w_rem_sh;
    logic [W:0]           w_diff;
    logic                 w_ge;
    logic [W-1:0]         w_rem_nx;
    logic [W-1:0]         w_quo_nx;
    logic [W-1:0]         w_quo_fix;
    logic [W-1:0]         w_rem_fix;

    div_prep #(
        .W (W)
    ) u_prep (
        .i_divw      (i_divw),
        .i_sign      (i_sign),
        .i_x         (i_x),
        .i_y         (i_y),
        .o_abs_x     (w_abs_x),
        .o_abs_y     (w_abs_y),
        .o_qs        (w_qs),
        .o_rs        (w_rs),
        .o_n         (w_n),
        .o_special   (w_special),
        .o_spec_quot (w_spec_quot),
        .o_spec_rem  (w_spec_rem)
    );

    // One restoring step plus the sign fix applied to the stepped values, so
    // the final step and the result register happen on the same edge.
    always_comb begin
        w_rem_sh = {rem_q, quo_q[W-1]};
        w_diff   = w_rem_sh - {1'b0, abs_y_q};
        w_ge     = ~w_diff[W];
        w_rem_nx = w_ge ? w_diff[W-1:0] : w_rem_sh[W-1:0];
        w_quo_nx = {quo_q[W-2:0], w_ge};

        w_quo_fix = qs_q ? (~w_quo_nx + 1'b1) : w_quo_nx;
        w_rem_fix = rs_q ? (~w_rem_nx + 1'b1) : w_rem_nx;
        if (divw_q) begin
            w_quo_fix = sext32(w_quo_fix);
            w_rem_fix = sext32(w_rem_fix);
        end
    end

    // Next-state and datapath loads for the IDLE/CALC/DONE sequence.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        abs_y_d    = abs_y_q;
        qs_d       = qs_q;
        rs_d       = rs_q;
        divw_d     = divw_q;
        res_quot_d = res_quot_q;
        res_rem_d  = res_rem_q;

        case (state_q)
            DIV_IDLE: begin
                if (i_valid && !i_flush) begin
                    if (w_special) begin
                        res_quot_d = w_spec_quot;
                        res_rem_d  = w_spec_rem;
                        state_d    = DIV_DONE;
                    end else begin
                        rem_d   = '0;
                        // Word dividends sit in the top half so N shifts drain them.
                        quo_d   = i_divw ? {w_abs_x[H-1:0], {H{1'b0}}} : w_abs_x;
                        abs_y_d = w_abs_y;
                        qs_d    = w_qs;
                        rs_d    = w_rs;
                        divw_d  = i_divw;
                        cnt_d   = w_n;
                        state_d = DIV_CALC;
                    end
                end
            end
            DIV_CALC: begin
                rem_d = w_rem_nx;
                quo_d = w_quo_nx;
                cnt_d = cnt_q - DIV_CNT_W'(1);
                if (cnt_q == DIV_CNT_W'(1)) begin
                    res_quot_d = w_quo_fix;
                    res_rem_d  = w_rem_fix;
                    state_d    = DIV_DONE;
                end
            end
            DIV_DONE: begin
                if (i_ready) begin
                    state_d = DIV_IDLE;
                end
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase

        if (i_flush) begin
            state_d = DIV_IDLE;
        end
    end

    // State and datapath registers; reset discards any partial division.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= DIV_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            abs_y_q    <= '0;
            qs_q       <= 1'b0;
            rs_q       <= 1'b0;
            divw_q     <= 1'b0;
            res_quot_q <= '0;
            res_rem_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            abs_y_q    <= abs_y_d;
            qs_q       <= qs_d;
            rs_q       <= rs_d;
            divw_q     <= divw_d;
            res_quot_q <= res_quot_d;
            res_rem_q  <= res_rem_d;
        end
    end

    assign o_ready = (state_q == DIV_IDLE);
    assign o_valid = (state_q == DIV_DONE);
    assign o_quot  = res_quot_q;
    assign o_rem   = res_rem_q;

endmodule
`default_nettype wire

// File: tb/tb_div.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div
//  Description : Self-checking bench for the divider: table of directed
//                vectors plus backpressure, reset and flush sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div;

    localparam int W = 64;

    typedef struct {
        string       name;
        logic        divw;
        logic        sign;
        logic [63:0] x;
        logic [63:0] y;
        logic [63:0] q;
        logic [63:0] r;
        int          lat;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         valid_in;
    logic         ready_out;
    logic         divw;
    logic         sign;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         valid_out;
    logic         ready_in;
    logic [W-1:0] quot;
    logic [W-1:0] rem;

    int n_cmp;
    int n_err;

    div #(.W(W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_flush (flush),
        .i_valid (valid_in),
        .o_ready (ready_out),
        .i_divw  (divw),
        .i_sign  (sign),
        .i_x     (x),
        .i_y     (y),
        .o_valid (valid_out),
        .i_ready (ready_in),
        .o_quot  (quot),
        .o_rem   (rem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one request, measure latency, check results, hold for backpressure, handshake.
    task automatic run_op(input vec_t v, input int hold);
        int          lat;
        logic        busy_bad;
        logic [63:0] q0;
        logic [63:0] r0;
        @(negedge clk);
        chk({v.name, " ready_before"}, 64'(ready_out), 64'd1);
        divw     = v.divw;
        sign     = v.sign;
        x        = v.x;
        y        = v.y;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        x        = '0;
        y        = '0;
        lat      = 1;
        busy_bad = 1'b0;
        while (!valid_out && lat < 200) begin
            if (ready_out) busy_bad = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        chk({v.name, " latency"}, 64'(lat), 64'(v.lat));
        chk({v.name, " ready_low_busy"}, 64'(busy_bad), 64'd0);
        chk({v.name, " quot"}, quot, v.q);
        chk({v.name, " rem"}, rem, v.r);
        q0 = quot;
        r0 = rem;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({v.name, " hold_valid"}, 64'(valid_out), 64'd1);
            chk({v.name, " hold_quot"}, quot, q0);
            chk({v.name, " hold_rem"}, rem, r0);
        end
        @(negedge clk);
        ready_in = 1'b1;
        @(posedge clk);
        #1;
        ready_in = 1'b0;
        chk({v.name, " valid_drop"}, 64'(valid_out), 64'd0);
        chk({v.name, " ready_back"}, 64'(ready_out), 64'd1);
    endtask

    // Start a full-width DIVU 100/7 and return just after the accept edge.
    task automatic start_op();
        @(negedge clk);
        divw     = 1'b0;
        sign     = 1'b0;
        x        = 64'd100;
        y        = 64'd7;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    vec_t vecs[16];
    vec_t bp;
    vec_t post;
    logic saw_valid;

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        flush    = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b0;
        divw     = 1'b0;
        sign     = 1'b0;
        x        = '0;
        y        = '0;

        vecs[0]  = '{"divu_100_7",     1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 65};
        vecs[1]  = '{"div_m7_2",       1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65};
        vecs[2]  = '{"rem_7_m2",       1'b0, 1'b1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 65};
        vecs[3]  = '{"divu_by_zero",   1'b0, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1};
        vecs[4]  = '{"div_overflow",   1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd0, 1};
        vecs[5]  = '{"divuw_max_1",    1'b1, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 33};
        vecs[6]  = '{"divw_overflow",  1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 64'd0, 1};
        vecs[7]  = '{"divw_hi_junk",   1'b1, 1'b1, 64'hDEAD_0000_0000_0014, 64'h1234_0000_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 33};
        vecs[8]  = '{"divuw_16",       1'b1, 1'b0, 64'h0000_0001_8000_0007, 64'h10, 64'h0000_0000_0800_0000, 64'd7, 33};
        vecs[9]  = '{"divu_max_3",     1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h5555_5555_5555_5555, 64'd0, 65};
        vecs[10] = '{"div_m5_zero",    1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB, 1};
        vecs[11] = '{"divuw_zero",     1'b1, 1'b0, 64'h0000_0000_8000_0000, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
        vecs[12] = '{"divu_small",     1'b0, 1'b0, 64'd5, 64'd9, 64'd0, 64'd5, 65};
        vecs[13] = '{"div_min_2",      1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'd2, 64'hC000_0000_0000_0000, 64'd0, 65};
        vecs[14] = '{"divw_m7_2",      1'b1, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 33};
        vecs[15] = '{"divuw_fff9_2",   1'b1, 1'b0, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'h0000_0000_7FFF_FFFC, 64'd1, 33};
        bp       = '{"backpressure",   1'b0, 1'b0, 64'd1000, 64'd10, 64'd100, 64'd0, 65};
        post     = '{"after_abort",    1'b0, 1'b0, 64'd81, 64'd9, 64'd9, 64'd0, 65};

        // Reset values while reset is held.
        repeat (2) @(posedge clk);
        #1;
        chk("reset ready", 64'(ready_out), 64'd1);
        chk("reset valid", 64'(valid_out), 64'd0);
        chk("reset quot", quot, 64'd0);
        chk("reset rem", rem, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i], 0);
        end

        // Result held for 10 cycles with the consumer stalled.
        run_op(bp, 10);
        run_op(vecs[0], 0);

        // Asynchronous reset in the middle of a calculation.
        start_op();
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset ready", 64'(ready_out), 64'd1);
        chk("midreset valid", 64'(valid_out), 64'd0);
        chk("midreset quot", quot, 64'd0);
        chk("midreset rem", rem, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(post, 0);

        // Flush at CALC cycle 20, with a competing request held across the flush.
        start_op();
        repeat (19) @(posedge clk);
        @(negedge clk);
        flush    = 1'b1;
        valid_in = 1'b1;
        x        = 64'd50;
        y        = 64'd0;
        @(posedge clk);
        #1;
        chk("flush ready", 64'(ready_out), 64'd1);
        chk("flush valid", 64'(valid_out), 64'd0);
        @(posedge clk);
        #1;
        chk("flush_vs_accept ready", 64'(ready_out), 64'd1);
        chk("flush_vs_accept valid", 64'(valid_out), 64'd0);
        @(negedge clk);
        flush    = 1'b0;
        valid_in = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (valid_out) saw_valid = 1'b1;
        end
        chk("flush no_stale_result", 64'(saw_valid), 64'd0);
        run_op(post, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
